// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with programmable flags, flush and optional overwrite
//   clk, reset_n (async, active-low)
//   wr_en/d_in, rd_en -> d_out (registered, valid with rd_ack)
//   flush: synchronous clear, dominates rd_en/wr_en
//   full/empty/almost_full/almost_empty: decoded from data_count
//   wr_ack/wr_err, rd_ack/rd_err: one-cycle registered handshake results
module fifo_param #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2,
  parameter bit OVERWRITE  = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    d_in,
  input  logic                     rd_en,
  input  logic                     flush,
  output logic [DATA_WIDTH-1:0]    d_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     wr_ack,
  output logic                     wr_err,
  output logic                     rd_ack,
  output logic                     rd_err,
  output logic [$clog2(DEPTH):0]   data_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_param: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_param: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_param: AE_LEVEL must be in 0..DEPTH-1");
  end
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;
  logic                  rd_ack_q, rd_ack_d, rd_err_q, rd_err_d;
  logic                  is_full, do_rd, do_wr, drop;
  assign is_full = count_q == CW'(DEPTH);
  // A write at full still goes in when a read frees a slot in the same
  // edge, or when overwrite mode discards the oldest entry instead.
  assign do_rd   = !flush && rd_en && count_q != '0;
  assign do_wr   = !flush && wr_en && (!is_full || rd_en || OVERWRITE);
  assign drop    = do_wr && !rd_en && is_full;
  always_comb begin
    head_d   = flush ? '0 : head_q + AW'(do_rd || drop);
    tail_d   = flush ? '0 : tail_q + AW'(do_wr);
    count_d  = flush ? '0 : count_q + CW'(do_wr) - CW'(do_rd || drop);
    dout_d   = do_rd ? mem[head_q] : dout_q;
    wr_ack_d = do_wr;
    wr_err_d = !flush && wr_en && !do_wr;
    rd_ack_d = do_rd;
    rd_err_d = !flush && rd_en && !do_rd;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
      rd_ack_q <= rd_ack_d;
      rd_err_q <= rd_err_d;
    end
  end
  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[tail_q] <= d_in;
  end
  assign d_out        = dout_q;
  assign data_count   = count_q;
  assign full         = is_full;
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= CW'(AF_LEVEL);
  assign almost_empty = count_q <= CW'(AE_LEVEL);
  assign wr_ack       = wr_ack_q;
  assign wr_err       = wr_err_q;
  assign rd_ack       = rd_ack_q;
  assign rd_err       = rd_err_q;
endmodule
